// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-controller arbiter: grant codes, FSM states and access-size encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LD   = 2'd2,
    GNT_ST   = 2'd3
  } gnt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] LEN_B      = 2'd0;
  localparam logic [1:0] LEN_H      = 2'd1;
  localparam logic [1:0] LEN_W      = 2'd2;
  localparam int         LEN_SIGNED = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection among fetch, load and store requests.
// Fixed priority store > load > fetch, overridden by the starve flag; flush masks speculative requesters.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_valid,
  input  logic ld_valid,
  input  logic st_valid,
  input  logic flush,
  input  logic starve,
  output gnt_e gnt
);

  always_comb begin
    if (starve && if_valid && !flush) gnt = GNT_IF;
    else if (st_valid)                gnt = GNT_ST;
    else if (ld_valid && !flush)      gnt = GNT_LD;
    else if (if_valid && !flush)      gnt = GNT_IF;
    else                              gnt = GNT_NONE;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter in front of the byte-serial memory controller.
// Optional fetch starvation guard is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_ready,
  output logic [31:0] ld_data,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_data,
  input  logic        mc_ready,
  input  logic [31:0] mc_res
);

  state_e      state_q, state_d;
  gnt_e        gnt_q, gnt_d, pick_gnt;
  logic        mc_valid_q, mc_valid_d;
  logic        mc_wr_q, mc_wr_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [2:0]  mc_len_q, mc_len_d;
  logic [31:0] mc_data_q, mc_data_d;
  logic        starve;
  logic        busy, kill, done;

  mem_arb_pick u_pick (
    .if_valid (if_valid),
    .ld_valid (ld_valid),
    .st_valid (st_valid),
    .flush    (flush),
    .starve   (starve),
    .gnt      (pick_gnt)
  );

  assign busy = (state_q == ST_BUSY);
  // A flush abandons an in-flight read; a committed store always runs to completion.
  assign kill = busy && flush && (gnt_q == GNT_IF || gnt_q == GNT_LD);
  assign done = busy && mc_ready && !kill;

  assign if_ready = rdy_in && done && (gnt_q == GNT_IF);
  assign ld_ready = rdy_in && done && (gnt_q == GNT_LD);
  assign st_ready = rdy_in && done && (gnt_q == GNT_ST);
  assign if_data  = mc_res;
  assign ld_data  = mc_res;

  assign mc_valid = mc_valid_q;
  assign mc_wr    = mc_wr_q;
  assign mc_addr  = mc_addr_q;
  assign mc_len   = mc_len_q;
  assign mc_data  = mc_data_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign starve = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (rdy_in && state_q == ST_IDLE) begin
      if (!if_valid || pick_gnt == GNT_IF)
        cnt_d = '0;
      else if ((pick_gnt == GNT_LD || pick_gnt == GNT_ST) && !flush && !starve)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign starve = 1'b0;
`endif

  // NOTE: every signal is given its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    mc_valid_d = mc_valid_q;
    mc_wr_d    = mc_wr_q;
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_data_d  = mc_data_q;
    if (rdy_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_gnt != GNT_NONE) begin
            state_d    = ST_BUSY;
            gnt_d      = pick_gnt;
            mc_valid_d = 1'b1;
            unique case (pick_gnt)
              GNT_IF: begin
                mc_wr_d   = 1'b0;
                mc_addr_d = if_addr;
                mc_len_d  = {1'b0, LEN_W};
                mc_data_d = '0;
              end
              GNT_LD: begin
                mc_wr_d   = 1'b0;
                mc_addr_d = ld_addr;
                mc_len_d  = ld_size;
                mc_data_d = '0;
              end
              GNT_ST: begin
                mc_wr_d   = 1'b1;
                mc_addr_d = st_addr;
                mc_len_d  = st_size;
                mc_data_d = st_data;
              end
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (done || kill) begin
            state_d    = ST_IDLE;
            gnt_d      = GNT_NONE;
            mc_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_NONE;
      mc_valid_q <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_len_q   <= '0;
      mc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      mc_valid_q <= mc_valid_d;
      mc_wr_q    <= mc_wr_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_data_q  <= mc_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued as requests are raised and
// checked against the controller-side outputs when each transaction is granted.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        if_valid, if_ready;
  logic [31:0] if_addr, if_data;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr, ld_data;
  logic [2:0]  ld_size;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_size;
  logic        mc_valid, mc_wr, mc_ready;
  logic [31:0] mc_addr, mc_data, mc_res;
  logic [2:0]  mc_len;

  typedef struct packed {
    gnt_e        who;
    logic [31:0] addr;
    logic [2:0]  len;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter dut (
    .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in), .flush (flush),
    .if_valid (if_valid), .if_addr (if_addr), .if_ready (if_ready), .if_data (if_data),
    .ld_valid (ld_valid), .ld_addr (ld_addr), .ld_size (ld_size),
    .ld_ready (ld_ready), .ld_data (ld_data),
    .st_valid (st_valid), .st_addr (st_addr), .st_size (st_size), .st_data (st_data),
    .st_ready (st_ready),
    .mc_valid (mc_valid), .mc_wr (mc_wr), .mc_addr (mc_addr), .mc_len (mc_len),
    .mc_data (mc_data), .mc_ready (mc_ready), .mc_res (mc_res)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input gnt_e who, input logic [31:0] addr, input logic [2:0] len,
                      input logic wr, input logic [31:0] data);
    txn_t t;
    t.who = who; t.addr = addr; t.len = len; t.wr = wr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic take_grant(output txn_t t, output int waits);
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!mc_valid && waits < 20);
    check("grant_seen", mc_valid, 1);
    if (exp_q.size() == 0) begin
      check("exp_available", 0, 1);
      t = '0;
    end else begin
      t = exp_q.pop_front();
    end
    check("mc_addr", mc_addr, t.addr);
    check("mc_wr", mc_wr, t.wr);
    check("mc_len", mc_len, t.len);
    if (t.wr) check("mc_data", mc_data, t.data);
  endtask

  task automatic drop_valid(input gnt_e who);
    case (who)
      GNT_IF:  if_valid = 1'b0;
      GNT_LD:  ld_valid = 1'b0;
      GNT_ST:  st_valid = 1'b0;
      default: ;
    endcase
  endtask

  task automatic serve(input int lat, input logic [31:0] res, output int waits);
    txn_t t;
    take_grant(t, waits);
    repeat (lat - 1) begin
      tick();
      check("no_early_ready", {if_ready, ld_ready, st_ready}, 0);
    end
    mc_ready = 1'b1;
    mc_res   = res;
    #1;
    check("if_ready", if_ready, t.who == GNT_IF);
    check("ld_ready", ld_ready, t.who == GNT_LD);
    check("st_ready", st_ready, t.who == GNT_ST);
    if (t.who == GNT_IF) check("if_data", if_data, res);
    if (t.who == GNT_LD) check("ld_data", ld_data, res);
    tick();
    mc_ready = 1'b0;
    drop_valid(t.who);
    check("mc_valid_after_done", mc_valid, 0);
    check("ready_single_pulse", {if_ready, ld_ready, st_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    int   w;

    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
    if_valid = 1'b0; if_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_size = '0;
    st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    mc_ready = 1'b0; mc_res = '0;

    #3;
    check("rst_mc_valid", mc_valid, 0);
    check("rst_mc_wr", mc_wr, 0);
    check("rst_mc_addr", mc_addr, 0);
    check("rst_mc_len", mc_len, 0);
    check("rst_mc_data", mc_data, 0);
    check("rst_readies", {if_ready, ld_ready, st_ready}, 0);
    #9 rst_in = 1'b1;
    tick();

    // Lone fetch, completion five cycles after grant.
    if_valid = 1'b1; if_addr = 32'h100;
    push(GNT_IF, 32'h100, 3'b010, 1'b0, '0);
    serve(5, 32'h00C0FFEE, w);

    // All three at once: store, then load, then fetch, one idle cycle apart.
    st_valid = 1'b1; st_addr = 32'h200; st_size = 3'b000; st_data = 32'hAB;
    ld_valid = 1'b1; ld_addr = 32'h300; ld_size = 3'b101;
    if_valid = 1'b1; if_addr = 32'h400;
    push(GNT_ST, 32'h200, 3'b000, 1'b1, 32'hAB);
    push(GNT_LD, 32'h300, 3'b101, 1'b0, '0);
    push(GNT_IF, 32'h400, 3'b010, 1'b0, '0);
    serve(2, 32'h0, w);
    check("st_grant_wait", w, 1);
    serve(3, 32'hFFFF8001, w);
    check("ld_grant_gap", w, 1);
    serve(2, 32'h12345678, w);
    check("if_grant_gap", w, 1);

    // Load aborted by flush on the same cycle as mc_ready; fetch held off while flush is high.
    ld_valid = 1'b1; ld_addr = 32'h40; ld_size = 3'b110;
    if_valid = 1'b1; if_addr = 32'h140;
    push(GNT_LD, 32'h40, 3'b110, 1'b0, '0);
    push(GNT_IF, 32'h140, 3'b010, 1'b0, '0);
    take_grant(t, w);
    tick();
    flush = 1'b1; mc_ready = 1'b1; mc_res = 32'hDEAD0000;
    #1;
    check("flush_no_ld_ready", ld_ready, 0);
    check("flush_no_if_ready", if_ready, 0);
    tick();
    mc_ready = 1'b0; ld_valid = 1'b0;
    check("flush_mc_valid", mc_valid, 0);
    tick();
    check("flush_masks_fetch", mc_valid, 0);
    flush = 1'b0;
    serve(2, 32'h5A5A0000, w);

    // Store survives a mid-transaction flush.
    st_valid = 1'b1; st_addr = 32'h500; st_size = 3'b010; st_data = 32'hDEADBEEF;
    push(GNT_ST, 32'h500, 3'b010, 1'b1, 32'hDEADBEEF);
    take_grant(t, w);
    tick();
    flush = 1'b1;
    tick();
    check("st_flush_mc_valid", mc_valid, 1);
    check("st_flush_mc_wr", mc_wr, 1);
    mc_ready = 1'b1;
    #1;
    check("st_flush_ready", st_ready, 1);
    tick();
    mc_ready = 1'b0; st_valid = 1'b0; flush = 1'b0;
    check("st_flush_done", mc_valid, 0);

    // Fetch held high while loads keep coming back.
    if_valid = 1'b1; if_addr = 32'h600;
    ld_valid = 1'b1; ld_addr = 32'h700; ld_size = 3'b010;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (k == 4) push(GNT_IF, 32'h600, 3'b010, 1'b0, '0);
      else        push(GNT_LD, 32'h700, 3'b010, 1'b0, '0);
`else
      push(GNT_LD, 32'h700, 3'b010, 1'b0, '0);
`endif
      serve(2, 32'hA000 + k, w);
      if_valid = 1'b1;
      ld_valid = 1'b1;
    end
    if_valid = 1'b0; ld_valid = 1'b0;
    tick();

    // Asynchronous reset while busy.
    ld_valid = 1'b1; ld_addr = 32'h800; ld_size = 3'b001;
    push(GNT_LD, 32'h800, 3'b001, 1'b0, '0);
    take_grant(t, w);
    #2 rst_in = 1'b0;
    mc_ready = 1'b1;
    #1;
    check("async_rst_mc_valid", mc_valid, 0);
    check("async_rst_mc_addr", mc_addr, 0);
    check("async_rst_ld_ready", ld_ready, 0);
    ld_valid = 1'b0; mc_ready = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    check("post_rst_idle", mc_valid, 0);
    check("post_rst_readies", {if_ready, ld_ready, st_ready}, 0);

    // rdy_in low freezes a store mid-transaction.
    st_valid = 1'b1; st_addr = 32'h900; st_size = 3'b001; st_data = 32'h1234;
    push(GNT_ST, 32'h900, 3'b001, 1'b1, 32'h1234);
    take_grant(t, w);
    rdy_in = 1'b0; mc_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("freeze_no_ready", st_ready, 0);
      tick();
      check("freeze_mc_valid", mc_valid, 1);
      check("freeze_mc_addr", mc_addr, 32'h900);
    end
    rdy_in = 1'b1;
    #1;
    check("unfreeze_st_ready", st_ready, 1);
    tick();
    mc_ready = 1'b0; st_valid = 1'b0;
    check("unfreeze_done", mc_valid, 0);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences the shared byte-serial MemoryController between three requesters: instruction fetch, load unit and committed-store buffer. Only one transaction is outstanding at a time. Request fields are latched at grant so the controller sees stable inputs. Routes the completion pulse and result back to the granted requester. Handles pipeline flush by abandoning speculative reads; committed stores are never dropped.

Parameters:
STARVE_LIMIT, 4, consecutive load/store grants tolerated while a fetch waits (used only with the starvation guard)
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous reset, active-low
rdy_in  in  1  global ready; low freezes all state
flush  in  1  pipeline clear (rob_clear)
if_valid  in  1  fetch request
if_addr  in  32  fetch address (always word)
if_ready  out  1  fetch done pulse
if_data  out  32  fetch word
ld_valid  in  1  load request
ld_addr  in  32  load address
ld_size  in  3  [1:0] 0 byte/1 half/2 word; [2] signed
ld_ready  out  1  load done pulse
ld_data  out  32  load result
st_valid  in  1  store request
st_addr  in  32  store address
st_size  in  3  same encoding as ld_size
st_data  in  32  store value
st_ready  out  1  store done pulse
mc_valid  out  1  controller enable, held high for the whole transaction
mc_wr  out  1  1 = write
mc_addr  out  32  latched address
mc_len  out  3  latched size
mc_data  out  32  latched write data
mc_ready  in  1  controller completion pulse
mc_res  in  32  controller read result

Behaviour:
- Reset (rst_in=0, async): state IDLE, grant NONE, mc_valid/mc_wr=0, mc_addr/mc_data=0, mc_len=0, starvation counter=0. All *_ready outputs are 0 during reset.
- rdy_in=0: registers hold, *_ready outputs forced 0, mc_valid holds its value.
- Requester contract: keep valid and fields stable until its ready pulse; treat a valid still high in the cycle after ready as a new request.
- States:
  - IDLE: choose a winner among valid requesters; on the next edge go to BUSY, set mc_valid=1, latch addr/size/data/wr and the grant.
  - Fetch latches mc_len=3'b010, mc_wr=0. Load latches mc_wr=0. Store latches mc_wr=1.
- Priority, no guard: store > load > fetch.
- flush in IDLE: fetch and load are masked that cycle; a store can still be granted.
- BUSY:
  - On mc_ready, the granted *_ready is driven combinationally the same cycle. *_data = mc_res; the data outputs are don't-care otherwise.
  - The next edge returns to IDLE with mc_valid=0, so there is at least one idle cycle between transactions.
- flush in BUSY with a fetch/load grant:
  - No ready pulse, even if mc_ready arrives in the same cycle.
  - Next edge: mc_valid=0, IDLE. The controller aborts on mc_valid low.
- flush in BUSY with a store grant: ignored; the store completes normally.
- Reset mid-transaction: immediate return to the reset values above.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - The counter increments on each load/store grant made while if_valid is high and flush is low, saturating at STARVE_LIMIT.
  - While counter==STARVE_LIMIT, fetch takes top priority.
  - The counter clears on a fetch grant, or in any IDLE cycle with if_valid low.
- Undefined: the counter is absent and fixed priority applies.

Decomposition:
- Package mem_arb_pkg:
  - grant encoding GNT_NONE/GNT_IF/GNT_LD/GNT_ST (2 bits);
  - state encoding ST_IDLE/ST_BUSY;
  - size constants LEN_B=0, LEN_H=1, LEN_W=2, LEN_SIGNED bit index 2.
- One combinational sub-module mem_arb_pick: inputs are the three valids, flush and the starve flag; output is the winning grant code.

Test Plan:
- if_valid at 0x100 alone, mc_ready 5 cycles after grant, mc_res=0x00C0FFEE -> mc_len=2, mc_wr=0; one-cycle if_ready with if_data=0x00C0FFEE; mc_valid low the next cycle.
- st (0x200, size 0, data 0xAB), ld (0x300) and if all valid at once -> order st, ld, if. Each grant is separated by one IDLE cycle. st_ready, ld_ready and if_ready each pulse exactly once.
- ld at 0x40 granted; flush on the same cycle as mc_ready -> no ld_ready; mc_valid=0 next cycle; a pending if is not granted while flush is high.
- st granted; flush asserted mid-transaction -> mc_valid stays 1, mc_wr=1; st_ready pulses on mc_ready.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, if_valid held high and a load/store request re-presented after every completion -> the fifth grant goes to fetch, after which load/store win again. Without the macro, fetch is never granted.
- rst_in pulsed low while BUSY -> mc_valid=0 asynchronously; after release, IDLE with no ready pulses. Holding rdy_in low for 3 cycles mid-transaction -> state frozen, no ready pulses, transaction completes afterwards.
